// File: rtl/diff_sq_pkg.sv
// diff_sq_pkg: shared constants, state type and accumulator sizing helper for diff_sq_accum.
package diff_sq_pkg;
    localparam int DATA_W_DEF = 10;

    typedef enum logic {ACCUM, HOLD} state_t;

    function automatic int acc_w_min(input int data_w, input int count);
        return data_w + $clog2(count);
    endfunction
endpackage

// File: rtl/diff_sq_accum_if.sv
// diff_sq_accum_if: product input stream and frame-total output stream of diff_sq_accum.
interface diff_sq_accum_if #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 12
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              drop_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, drop_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, drop_err
    );
endinterface

// File: rtl/diff_sq_frame_ctr.sv
// diff_sq_frame_ctr: counts accepted products in a frame and flags the last one.
module diff_sq_frame_ctr #(
    parameter int COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic last
);
    localparam int CW = $clog2(COUNT);

    logic [CW-1:0] cnt;

    assign last = cnt == CW'(COUNT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (adv)
            cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/diff_sq_accum.sv
// diff_sq_accum: sums COUNT products per frame and presents the total on a valid/ready output.
// Optional DIFF_SQ_ACCUM_MAX_TRACK_EN adds out_max, the largest product of the frame.
module diff_sq_accum
    import diff_sq_pkg::*;
#(
    parameter int COUNT  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
`ifdef DIFF_SQ_ACCUM_MAX_TRACK_EN
    output logic [DATA_W-1:0] out_max,
`endif
    diff_sq_accum_if.slave    bus
);
    if (COUNT < 2 || COUNT > 64) begin : g_bad_count
        $fatal(1, "diff_sq_accum: COUNT out of range 2..64");
    end
    if (ACC_W < acc_w_min(DATA_W, COUNT)) begin : g_bad_acc_w
        $fatal(1, "diff_sq_accum: ACC_W too narrow for DATA_W and COUNT");
    end

    state_t           state, state_n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_n;
    logic             accept;
    logic             last;

    assign bus.in_ready  = state == ACCUM && !clr;
    assign bus.out_valid = state == HOLD;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sum_n         = acc + ACC_W'(bus.in_data);

    diff_sq_frame_ctr #(.COUNT(COUNT)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .adv   (accept),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ACCUM;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clr)
            state_n = ACCUM;
        else if (accept && last)
            state_n = HOLD;
        else if (state == HOLD && bus.out_ready)
            state_n = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            acc <= '0;
        else if (accept)
            acc <= last ? '0 : sum_n;
    end

    // out_sum survives clr; it is only meaningful while out_valid is high
    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.out_sum <= '0;
        else if (accept && last)
            bus.out_sum <= sum_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            bus.drop_err <= 1'b0;
        else if (bus.in_valid && !bus.in_ready)
            bus.drop_err <= 1'b1;
    end

`ifdef DIFF_SQ_ACCUM_MAX_TRACK_EN
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] mx_n;

    assign mx_n = bus.in_data > mx ? bus.in_data : mx;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            mx <= '0;
        else if (accept)
            mx <= last ? '0 : mx_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            out_max <= '0;
        else if (accept && last)
            out_max <= mx_n;
    end
`endif
endmodule

// File: tb/tb_diff_sq_accum.sv
// tb_diff_sq_accum: directed checks of diff_sq_accum with COUNT=4, DATA_W=10, ACC_W=12.
module tb_diff_sq_accum;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    diff_sq_accum_if #(.DATA_W(10), .ACC_W(12)) bus ();

`ifdef DIFF_SQ_ACCUM_MAX_TRACK_EN
    logic [9:0] out_max;
`endif

    diff_sq_accum #(.COUNT(4), .DATA_W(10), .ACC_W(12)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
`ifdef DIFF_SQ_ACCUM_MAX_TRACK_EN
        .out_max (out_max),
`endif
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 10'(v[i]);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_sum", 32'(bus.out_sum), 0);
        chk("rst_drop_err", 32'(bus.drop_err), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // basic frame, consumer always ready
        bus.out_ready = 1'b1;
        send4(93, 240, 32, 32);
        chk("basic_valid", 32'(bus.out_valid), 1);
        chk("basic_sum", 32'(bus.out_sum), 397);
        chk("basic_in_ready_hold", 32'(bus.in_ready), 0);
        step();
        chk("basic_valid_one_cycle", 32'(bus.out_valid), 0);
        chk("basic_in_ready_after", 32'(bus.in_ready), 1);
        chk("basic_sum_retained", 32'(bus.out_sum), 397);

        // back-pressure with a dropped product during HOLD
        bus.out_ready = 1'b0;
        send4(93, 240, 32, 32);
        chk("bp_valid", 32'(bus.out_valid), 1);
        chk("bp_sum", 32'(bus.out_sum), 397);
        bus.in_valid = 1'b1;
        bus.in_data  = 10'd7;
        step();
        bus.in_valid = 1'b0;
        chk("bp_drop_err", 32'(bus.drop_err), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_sum", 32'(bus.out_sum), 397);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_handshake_valid", 32'(bus.out_valid), 0);
        chk("bp_handshake_sum", 32'(bus.out_sum), 397);
        chk("bp_drop_sticky", 32'(bus.drop_err), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_drop_err", 32'(bus.drop_err), 0);

        // full-scale products must not wrap
        send4(1023, 1023, 1023, 1023);
        chk("max_valid", 32'(bus.out_valid), 1);
        chk("max_sum", 32'(bus.out_sum), 4092);
        step();

        // clr mid-frame discards partial sum and ignores concurrent product
        bus.in_valid = 1'b1;
        bus.in_data  = 10'd93;
        step();
        bus.in_data  = 10'd240;
        step();
        bus.in_data  = 10'd32;
        clr = 1'b1;
        #1;
        chk("clr_in_ready", 32'(bus.in_ready), 0);
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        send4(1, 2, 3, 4);
        chk("clr_valid", 32'(bus.out_valid), 1);
        chk("clr_sum", 32'(bus.out_sum), 10);
        chk("clr_no_drop", 32'(bus.drop_err), 0);
        step();

        // sync reset during HOLD discards the pending total
        bus.out_ready = 1'b0;
        send4(93, 240, 32, 32);
        chk("rh_sum_before", 32'(bus.out_sum), 397);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rh_valid", 32'(bus.out_valid), 0);
        chk("rh_sum", 32'(bus.out_sum), 0);
        chk("rh_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        send4(5, 5, 5, 5);
        chk("rh_frame_valid", 32'(bus.out_valid), 1);
        chk("rh_frame_sum", 32'(bus.out_sum), 20);
        step();

`ifdef DIFF_SQ_ACCUM_MAX_TRACK_EN
        send4(93, 240, 32, 240);
        chk("mt_sum", 32'(bus.out_sum), 605);
        chk("mt_max", 32'(out_max), 240);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/diff_sq_accum.md
Name: diff_sq_accum

Overview:
- Downstream consumer of the difference-of-squares pipeline's 10-bit product stream.
- Sums a fixed number of valid products into one frame total.
- Presents each total on a valid/ready output handshake.
- Back-pressures its input while a total is pending and flags any product it has to drop.

Parameters:
- COUNT, 4: products summed per frame; legal range 2..64.
- DATA_W, 10: width of the incoming product.
- ACC_W, 12: accumulator and out_sum width. Elaboration fails (fatal) if ACC_W < DATA_W + clog2(COUNT).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- clr  in  1  synchronous frame restart; one-cycle pulse or level.
- in_valid  in  1  in_data carries a product this cycle.
- in_data  in  DATA_W  product, unsigned.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_sum holds a completed frame total.
- out_ready  in  1  consumer takes out_sum this cycle.
- out_sum  out  ACC_W  frame total, unsigned.
- drop_err  out  1  sticky: a product arrived while in_ready was 0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge) sets:
  - state=ACCUM, acc=0, cnt=0
  - out_valid=0, out_sum=0, drop_err=0
- Reset takes priority over every other event. A reset mid-frame discards the partial sum. A reset while out_valid=1 discards the pending total.
- States:
  - ACCUM: collecting products.
  - HOLD: total pending on the output.
- in_ready = (state==ACCUM) && !clr. It is combinational from registered state and clr only, with no path from out_ready.
- Accept means in_valid && in_ready at an edge. On accept:
  - If cnt < COUNT-1: acc += in_data, cnt += 1.
  - If cnt == COUNT-1: out_sum <= acc + in_data, out_valid <= 1, acc <= 0, cnt <= 0, state -> HOLD.
- Latency: out_valid rises on the edge that accepts the COUNT-th product, so it is visible the following cycle.
- HOLD:
  - out_sum and out_valid are stable until handshake.
  - On out_valid && out_ready: out_valid <= 0, state -> ACCUM. The first new product can be accepted the cycle after the handshake (one bubble).
- out_sum retains its last value after the handshake; it is only meaningful while out_valid=1.
- Arithmetic:
  - Zero-extend in_data to ACC_W.
  - The ACC_W check guarantees no overflow, so no saturation logic is needed.
- Drop: in_valid && !in_ready at an edge, and clr=0, sets drop_err=1. The product is lost and acc/cnt are unchanged.
- clr=1 at an edge (rst_n=1):
  - acc=0, cnt=0, out_valid=0, drop_err=0, state -> ACCUM.
  - Any concurrent in_valid is ignored, not counted and not flagged.
  - clr wins over a simultaneous accept or output handshake.
- in_valid may be low in any cycle. Gaps do not affect the partial sum.

Optional Feature:
- Macro: DIFF_SQ_ACCUM_MAX_TRACK_EN.
- When defined:
  - Adds port out_max (out, DATA_W): the largest in_data accepted in the frame, registered alongside out_sum.
  - The running max resets to 0 on rst_n, clr and frame completion.
  - A tie keeps the existing value.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package diff_sq_pkg holds:
  - DATA_W default constant.
  - State enum type (ACCUM, HOLD).
  - clog2-based ACC_W minimum helper function.
- Optional sub-module diff_sq_frame_ctr: cnt register, last-product detect and clr/reset handling. Accumulator and handshake stay in the top.

Test Plan:
- Basic frame: products 93, 240, 32, 32 on consecutive cycles, out_ready=1 → out_valid for exactly one cycle, out_sum=397. Next frame then accepts after one bubble.
- Back-pressure: same frame with out_ready=0 for 5 cycles → out_sum holds 397, in_ready=0 throughout. A product presented during HOLD sets drop_err=1. out_sum is still 397 at the handshake.
- Max range, COUNT=4: four products of 1023 → out_sum=4092, no wrap. Elaborating with ACC_W=11 fails.
- clr mid-frame: 93, 240, then clr with in_valid=1 and data 32, then 1, 2, 3, 4 → out_sum=10. drop_err stays 0.
- Sync reset: assert rst_n=0 for one edge during HOLD (out_sum=397) → next cycle out_valid=0, out_sum=0, in_ready=1. A following frame of 5, 5, 5, 5 gives 20.
- With DIFF_SQ_ACCUM_MAX_TRACK_EN defined: frame 93, 240, 32, 240 → out_sum=605, out_max=240.
